// File: rtl/core_ctrl_pkg.sv
// Shared constants, state encoding and control-word type for the multicycle core.
// Imported by the control FSM, its wait timer and the testbench.
package core_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_ADDR   = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_WB_MEM = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_WB_ALU = 4'd7,
    ST_BRANCH = 4'd8,
    ST_FAULT  = 4'd9
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       fault;
  } ctrl_t;

  // States that own the memory port and are therefore watched by the timer.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been waiting and flags the timeout cycle.
// The counter saturates rather than wrapping; TIMEOUT of 0 disables the flag.
module mem_wait_timer
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int               LIMIT_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT     = LIMIT_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (active && !ready && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // A ready in the limit cycle completes the access, so it suppresses expiry.
  assign expired = (TIMEOUT != 0) && active && !ready && (cnt_reg == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I-subset core (R-type, LW, SW, BEQ).
// Datapath controls are decoded from the state; memory-completion strobes are gated by mem_ready.
module multicycle_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       fault,
  output logic [3:0] state_dbg
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_next;
  ctrl_t  ctrl_out;
  logic   wait_clear;
  logic   wait_expired;

  // Clear the wait counter on every transition into a memory state.
  assign wait_clear = is_mem_state(state_next) && (state_next != state_reg);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .active  (is_mem_state(state_reg)),
    .ready   (mem_ready),
    .expired (wait_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (mem_ready)         state_next = ST_DECODE;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = ST_ADDR;
          OP_R:         state_next = ST_EXEC_R;
          OP_BEQ:       state_next = ST_BRANCH;
          default:      state_next = ST_FAULT;
        endcase
      end
      ST_ADDR: begin
        if (opcode == OP_LW)      state_next = ST_MEM_RD;
        else if (opcode == OP_SW) state_next = ST_MEM_WR;
        else                      state_next = ST_FAULT;
      end
      ST_MEM_RD: begin
        if (mem_ready)         state_next = ST_WB_MEM;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (mem_ready)         state_next = ST_FETCH;
        else if (wait_expired) state_next = ST_FAULT;
      end
      ST_WB_MEM: state_next = ST_FETCH;
      ST_EXEC_R: state_next = ST_WB_ALU;
      ST_WB_ALU: state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    ctrl_next = '0;
    case (state_reg)
      ST_FETCH: begin
        ctrl_next.mem_req   = 1'b1;
        ctrl_next.alu_src_b = SRCB_FOUR;
        ctrl_next.alu_op    = ALU_ADD;
        ctrl_next.ir_write  = mem_ready;
        ctrl_next.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // old_pc + imm lands in ALUOut as the branch target.
        ctrl_next.alu_src_b = SRCB_IMM;
        ctrl_next.alu_op    = ALU_ADD;
      end
      ST_ADDR: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = SRCB_IMM;
        ctrl_next.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl_next.mem_req = 1'b1;
        ctrl_next.iord    = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_next.mem_req = 1'b1;
        ctrl_next.iord    = 1'b1;
        ctrl_next.mem_we  = 1'b1;
        ctrl_next.retire  = mem_ready;
      end
      ST_WB_MEM: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = 1'b1;
        ctrl_next.retire     = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = SRCB_RS2;
        ctrl_next.alu_op    = ALU_FUNCT;
      end
      ST_WB_ALU: begin
        ctrl_next.reg_write = 1'b1;
        ctrl_next.retire    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = SRCB_RS2;
        ctrl_next.alu_op    = ALU_SUB;
        ctrl_next.pc_src    = 1'b1;
        ctrl_next.pc_write  = zero;
        ctrl_next.retire    = 1'b1;
      end
      ST_FAULT: ctrl_next.fault = 1'b1;
      default:  ctrl_next = '0;
    endcase
  end

  // Reset silences every output, including the debug state.
  assign ctrl_out   = rst ? '0 : ctrl_next;
  assign state_dbg  = rst ? 4'd0 : state_reg;

  assign mem_req    = ctrl_out.mem_req;
  assign mem_we     = ctrl_out.mem_we;
  assign iord       = ctrl_out.iord;
  assign ir_write   = ctrl_out.ir_write;
  assign pc_write   = ctrl_out.pc_write;
  assign pc_src     = ctrl_out.pc_src;
  assign reg_write  = ctrl_out.reg_write;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign retire     = ctrl_out.retire;
  assign fault      = ctrl_out.fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model queues the expected
// control word of every cycle, and a negedge monitor pops and compares it.
module tb_multicycle_ctrl;
  import core_ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, alu_src_a, retire, fault;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_dbg;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .retire     (retire),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  logic [18:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, retire, fault, state_dbg};

  logic [18:0] exp_q[$];
  int          id_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc_id = 0;
  bit          aborted;
  int          cyc;
  int          abort_at;

  // Control word required by the state table for one cycle.
  function automatic logic [18:0] exp_out(input state_t s, input bit rdy, input bit z);
    logic       req, we, ad, irw, pcw, pcs, rw, m2r, sa, ret, flt;
    logic [1:0] sb, op;
    logic [3:0] sv;
    req = 0; we = 0; ad = 0; irw = 0; pcw = 0; pcs = 0; rw = 0; m2r = 0;
    sa = 0; ret = 0; flt = 0; sb = 2'b00; op = 2'b00;
    sv = s;
    case (s)
      ST_FETCH:  begin req = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: begin sb = 2'b10; end
      ST_ADDR:   begin sa = 1; sb = 2'b10; end
      ST_MEM_RD: begin req = 1; ad = 1; end
      ST_MEM_WR: begin req = 1; ad = 1; we = 1; ret = rdy; end
      ST_WB_MEM: begin rw = 1; m2r = 1; ret = 1; end
      ST_EXEC_R: begin sa = 1; sb = 2'b00; op = 2'b10; end
      ST_WB_ALU: begin rw = 1; ret = 1; end
      ST_BRANCH: begin sa = 1; op = 2'b01; pcs = 1; pcw = z; ret = 1; end
      ST_FAULT:  begin flt = 1; end
      default:   begin end
    endcase
    return {req, we, ad, irw, pcw, pcs, rw, m2r, sa, sb, op, ret, flt, sv};
  endfunction

  task automatic do_cycle(input bit r, input logic [6:0] op, input bit rdy, input bit z,
                          input logic [18:0] e);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = rdy; zero = z;
    cyc_id++;
    exp_q.push_back(r ? 19'd0 : e);
    id_q.push_back(cyc_id);
  endtask

  task automatic step(input state_t s, input bit rdy, input bit z, input logic [6:0] op);
    if (aborted) return;
    cyc++;
    if (abort_at != 0 && cyc == abort_at) begin
      do_cycle(1'b1, op, rdy, z, 19'd0);
      aborted = 1;
      return;
    end
    do_cycle(1'b0, op, rdy, z, exp_out(s, rdy, z));
  endtask

  // One memory access: w idle cycles then ready, or a timeout once w reaches the limit.
  task automatic mem_phase(input state_t s, input int w, input logic [6:0] op, input bit rand_op,
                           output bit faulted);
    int idle;
    idle = (w < TO) ? w : TO;
    for (int i = 0; i < idle; i++)
      step(s, 1'b0, 1'($urandom), rand_op ? 7'($urandom) : op);
    faulted = (w >= TO);
    if (!faulted) step(s, 1'b1, 1'($urandom), rand_op ? 7'($urandom) : op);
  endtask

  task automatic run_instr(input logic [6:0] op, input int wf, input int wd, input bit z,
                           input int abort_cycle, input int hold);
    bit f;
    aborted = 0; cyc = 0; abort_at = abort_cycle;
    mem_phase(ST_FETCH, wf, op, 1'b1, f);
    if (!f) begin
      step(ST_DECODE, 1'($urandom), 1'($urandom), op);
      if (op == OP_LW) begin
        step(ST_ADDR, 1'($urandom), 1'($urandom), op);
        mem_phase(ST_MEM_RD, wd, op, 1'b0, f);
        if (!f) step(ST_WB_MEM, 1'($urandom), 1'($urandom), op);
      end else if (op == OP_SW) begin
        step(ST_ADDR, 1'($urandom), 1'($urandom), op);
        mem_phase(ST_MEM_WR, wd, op, 1'b0, f);
      end else if (op == OP_R) begin
        step(ST_EXEC_R, 1'($urandom), 1'($urandom), op);
        step(ST_WB_ALU, 1'($urandom), 1'($urandom), op);
      end else if (op == OP_BEQ) begin
        step(ST_BRANCH, 1'($urandom), z, op);
      end else begin
        f = 1;
      end
    end
    if (f) begin
      for (int i = 0; i < hold; i++) step(ST_FAULT, 1'($urandom), 1'($urandom), op);
      if (!aborted) do_cycle(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 19'd0);
    end
    $display("instr op=%b wf=%0d wd=%0d z=%0d abort_at=%0d cycles=%0d aborted=%0d fault=%0d",
             op, wf, wd, z, abort_cycle, cyc, aborted, f);
  endtask

  initial begin : monitor
    logic [18:0] e;
    int          id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL ctrl_word cycle %0d: got %b required %b", id, act, e);
        end
      end
    end
  end

  initial begin : driver
    logic [6:0] op;
    int         pick, wf, wd;
    repeat (3) do_cycle(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 19'd0);

    run_instr(OP_R,   0, 0, 1'b0, 0, 0);
    run_instr(OP_LW,  2, 3, 1'b0, 0, 0);
    run_instr(OP_BEQ, 0, 0, 1'b1, 0, 0);
    run_instr(OP_BEQ, 0, 0, 1'b0, 0, 0);
    run_instr(7'b1111111, 0, 0, 1'b0, 0, 20);
    run_instr(OP_SW,  0, 4, 1'b0, 0, 3);
    run_instr(OP_SW,  0, 3, 1'b0, 0, 0);
    run_instr(OP_LW,  0, 3, 1'b0, 5, 0);
    run_instr(OP_SW,  4, 0, 1'b0, 0, 2);

    for (int n = 0; n < 160; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 2)      op = OP_R;
      else if (pick < 4) op = OP_LW;
      else if (pick < 6) op = OP_SW;
      else if (pick < 8) op = OP_BEQ;
      else begin
        do op = 7'($urandom);
        while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ);
      end
      wf = ($urandom_range(0, 9) < 9) ? $urandom_range(0, TO - 1) : TO;
      wd = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TO - 1) : TO;
      run_instr(op, wf, wd, 1'($urandom),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0,
                $urandom_range(1, 5));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
